// File: rtl/demux_1x2_buffered.sv
// 1:2 valid/ready demultiplexer: one producer stream is steered by sel into one of two
// independent output FIFOs, each with its own delivered-word counter.

module demux_1x2_buffered_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             valid_o,
    output logic             full_o,
    output logic [CNT_W-1:0] cnt_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0] occ_q, occ_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             push, pop;

    // Full is judged on current occupancy only, so a same-cycle pop never frees a full slot.
    assign full_o  = (occ_q == OCC_W'(DEPTH));
    assign valid_o = (occ_q != '0);
    assign data_o  = valid_o ? mem_q[rd_ptr_q] : '0;
    assign cnt_o   = cnt_q;
    assign push    = push_i && !full_o;
    assign pop     = pop_i && valid_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        cnt_d    = cnt_q;
        if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
            cnt_d    = cnt_q + CNT_W'(1);
        end
        if (push && !pop)      occ_d = occ_q + OCC_W'(1);
        else if (pop && !push) occ_d = occ_q - OCC_W'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && push) mem_q[wr_ptr_q] <= data_i;
    end
endmodule

module demux_1x2_buffered #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] e,
    input  logic             sel,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] sal1,
    output logic             sal1_valid,
    input  logic             sal1_ready,
    output logic [WIDTH-1:0] sal2,
    output logic             sal2_valid,
    input  logic             sal2_ready,
    output logic [CNT_W-1:0] cnt1,
    output logic [CNT_W-1:0] cnt2
);
    logic full1, full2;
    logic push1, push2;

    // Readiness depends only on the selected FIFO, never on in_valid or consumer ready.
    assign in_ready = sel ? !full2 : !full1;
    assign push1    = in_valid && in_ready && !sel;
    assign push2    = in_valid && in_ready && sel;

    demux_1x2_buffered_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) u_fifo1 (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push1),
        .data_i  (e),
        .pop_i   (sal1_ready),
        .data_o  (sal1),
        .valid_o (sal1_valid),
        .full_o  (full1),
        .cnt_o   (cnt1)
    );

    demux_1x2_buffered_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) u_fifo2 (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push2),
        .data_i  (e),
        .pop_i   (sal2_ready),
        .data_o  (sal2),
        .valid_o (sal2_valid),
        .full_o  (full2),
        .cnt_o   (cnt2)
    );
endmodule
